cen_gen: RTL and testbench
==========================

# cen_gen

Parametrised multi-channel fractional clock-enable generator. It runs on the PLL's fast output clock and derives per-channel clock-enable pulses at rate f_clk·num/den, using phase accumulators that software can reprogram. It also sequences PLL lock into a clean core reset. It sits between the PLL wrapper and the game core, replacing fixed divide-by-N enables.

## Interface
- NUM_CH, 2, number of enable channels (1..8)
- ACC_W, 16, width of num/den/accumulator
- LOCK_CYCLES, 1024, consecutive synchronised-locked cycles required before RUN (≥2)
- DEF_NUM, 1, reset numerator for every channel
- DEF_DEN, 2, reset denominator for every channel
- clk  in  1  single clock (fast PLL output); all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- locked  in  1  PLL locked, asynchronous to clk
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  3  channel index for write
- cfg_num  in  ACC_W  new numerator
- cfg_den  in  ACC_W  new denominator
- cen  out  NUM_CH  one-cycle enable pulses
- cen_b  out  NUM_CH  half-phase enable pulses (see Configuration)
- rst_out_n  out  1  core reset, active-low, registered
- running  out  1  state == RUN

## Operation
- `locked` passes through a 2-flop synchroniser to give `lk_s`.
- FSM states:
  - WAIT_LOCK (reset state): counter = 0. Goes to STABLE when `lk_s` = 1.
  - STABLE: counter increments each cycle. `lk_s` = 0 sends it back to WAIT_LOCK with counter = 0. Counter == LOCK_CYCLES-1 sends it to RUN.
  - RUN: `lk_s` = 0 sends it to WAIT_LOCK, clears all accumulators and forces cen/cen_b to 0 from the next cycle.
- Per-channel registers: num, den, acc, all ACC_W wide. Reset values: num = DEF_NUM, den = DEF_DEN, acc = 0.
- Each RUN edge: sum = acc + num, computed ACC_W+1 bits wide.
  - If sum ≥ den: acc ← sum − den and cen ← 1.
  - Otherwise: acc ← sum and cen ← 0.
- Outside RUN: acc held at 0, cen = 0.
- den = 0: channel disabled. acc held at 0, cen = 0.
- num > den: treated as num = den, so cen is continuously high in RUN.
- Config write: when cfg_we = 1 and cfg_ch < NUM_CH, the channel's num/den load on that edge and its acc clears to 0.
  - cen for that edge is computed from the old num/den/acc.
  - Writes with cfg_ch ≥ NUM_CH are ignored.
  - Writes are accepted in every FSM state.
- rst_out_n ← (next state == RUN), so it rises on the same edge that enters RUN.
- running is combinational from the state register.

## Timing
- Reset values: cen = 0, cen_b = 0, rst_out_n = 0, running = 0, state = WAIT_LOCK, all accumulators 0.
- locked → lk_s latency: 2 edges.
- RUN entered LOCK_CYCLES edges after the first lk_s = 1 edge. Minimum from the locked rise to RUN: LOCK_CYCLES + 2 edges.
- cen is registered, one-cycle high per wrap. Long-run average rate is exactly num/den; pulse spacing is ⌊den/num⌋ or ⌈den/num⌉ cycles.
- With num = 1, den = 2: first cen is high in the cycle after the 2nd RUN edge, then every 2nd cycle.
- Lock loss: 2 edges after `locked` falls, state goes to WAIT_LOCK. On that same edge rst_out_n = 0 and cen = 0.
- If rst_n is asserted mid-operation, every output returns to its reset value immediately (asynchronous).

## Configuration
- Macro `CEN_GEN_PHASE_EN`.
- Defined: cen_b is generated per channel, registered, with half = den>>1. cen_b ← 1 when either:
  - no wrap, and acc < half ≤ sum; or
  - wrap, and (sum − den) ≥ half.
  - Same gating as cen: 0 outside RUN and for den = 0.
  - Result: with num = 1, den = 2, cen_b pulses on the cycles between cen pulses.
- Not defined: cen_b tied to 0. No half-phase logic is synthesised; cen behaviour is unchanged.

## Test plan
- Reset then locked = 1 with LOCK_CYCLES = 16 → rst_out_n and running rise 18 edges after the locked rise. cen stays 0 until then.
- locked glitches low for 1 cycle at STABLE count 10 → counter restarts. RUN is reached 16 edges after lk_s returns high.
- Default 1/2 in RUN → cen = 1,0,1,0…; with the macro, cen_b is the complement pattern.
- Write ch1 num = 3, den = 8 → over 800 RUN cycles exactly 300 cen pulses, spacing only 2 or 3 cycles. Write to cfg_ch = 5 with NUM_CH = 2 → no change.
- den = 0 on ch0 → cen[0] stays 0. num = 9, den = 4 → cen continuously 1 in RUN.
- locked drops in RUN → 2 edges later rst_out_n = 0 and all cen = 0. Relock → accumulators restart from 0.

Source files
------------

// File: rtl/cen_gen.sv
// cen_gen: multi-channel fractional clock-enable generator (rate num/den) with PLL-lock reset sequencing.
// Define CEN_GEN_PHASE_EN to build the half-phase enables on cen_b; otherwise cen_b is tied to 0.

module cen_gen_ch #(
    parameter int ACC_W   = 16,
    parameter int DEF_NUM = 1,
    parameter int DEF_DEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_num,
    input  logic [ACC_W-1:0] wr_den,
    output logic             cen,
    output logic             cen_b
);
    logic [ACC_W-1:0] num, den, acc, num_eff, rem;
    logic [ACC_W:0]   sum;
    logic             wrap, en;

    // num > den saturates to den so the channel fires on every active edge
    assign num_eff = (num > den) ? den : num;
    assign sum     = {1'b0, acc} + {1'b0, num_eff};
    assign wrap    = sum >= {1'b0, den};
    assign rem     = sum[ACC_W-1:0] - den;
    assign en      = active && (den != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num <= ACC_W'(DEF_NUM);
            den <= ACC_W'(DEF_DEN);
            acc <= '0;
            cen <= 1'b0;
        end else begin
            cen <= en && wrap;
            if (wr) begin
                num <= wr_num;
                den <= wr_den;
                acc <= '0;
            end else if (!en) begin
                acc <= '0;
            end else begin
                acc <= wrap ? rem : sum[ACC_W-1:0];
            end
        end
    end

`ifdef CEN_GEN_PHASE_EN
    logic [ACC_W-1:0] half;
    logic             ph;

    assign half = den >> 1;
    assign ph   = wrap ? (rem >= half) : ((acc < half) && ({1'b0, half} <= sum));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cen_b <= 1'b0;
        else        cen_b <= en && ph;
    end
`else
    assign cen_b = 1'b0;
`endif
endmodule

module cen_gen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int DEF_NUM     = 1,
    parameter int DEF_DEN     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic [NUM_CH-1:0] cen,
    output logic [NUM_CH-1:0] cen_b,
    output logic              rst_out_n,
    output logic              running
);
    localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lk_m, lk_s, lk_ok, active;

    // The FSM acts on the value lk_s is loading this edge, so state changes coincide
    // with lk_s changes; lk_s itself is always 1 while in STABLE/RUN.
    assign lk_ok   = lk_m && lk_s;
    assign running = (state == RUN);
    assign active  = (state == RUN) && lk_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_m      <= 1'b0;
            lk_s      <= 1'b0;
            state     <= WAIT_LOCK;
            cnt       <= '0;
            rst_out_n <= 1'b0;
        end else begin
            lk_m      <= locked;
            lk_s      <= lk_m;
            rst_out_n <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (lk_m) state <= STABLE;
                end
                STABLE: begin
                    if (!lk_ok) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        state     <= RUN;
                        rst_out_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_ok) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        rst_out_n <= 1'b1;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cen_gen_ch #(.ACC_W(ACC_W), .DEF_NUM(DEF_NUM), .DEF_DEN(DEF_DEN)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .active (active),
            .wr     (cfg_we && (cfg_ch == 3'(i))),
            .wr_num (cfg_num),
            .wr_den (cfg_den),
            .cen    (cen[i]),
            .cen_b  (cen_b[i])
        );
    end
endmodule

// File: tb/tb_cen_gen.sv
// Bench for cen_gen: closed-form phase model (k-th active edge -> k*num mod den) checked every cycle,
// plus literal expectations for lock timing, pulse counts and the half-phase pattern.
`timescale 1ns/1ps
module tb_cen_gen;
    localparam int NUM_CH = 2;
    localparam int ACC_W  = 16;
    localparam int LC     = 16;

    logic              clk = 1'b0;
    logic              rst_n, locked, cfg_we;
    logic [2:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_num, cfg_den;
    logic [NUM_CH-1:0] cen, cen_b;
    logic              rst_out_n, running;

    cen_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LC), .DEF_NUM(1), .DEF_DEN(2)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .cen(cen), .cen_b(cen_b),
        .rst_out_n(rst_out_n), .running(running));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(string nm, longint act, longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Lock: RUN holds after LC+1 consecutive edges on which the synchronised lock is high.
    // Channel: after k active edges since the last clear, phase = k*num; cen fires when the
    // running phase crosses a multiple of den.
    bit                m_lkp, m_run, lk_now, run_new, act;
    int                m_len, len_new;
    longint            m_n[NUM_CH], m_d[NUM_CH], m_k[NUM_CH];
    longint            nn, a, s, h;
    logic [NUM_CH-1:0] e_cen, e_cenb, c_v, b_v;

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            m_lkp <= 1'b0; m_len <= 0; m_run <= 1'b0; e_cen <= '0; e_cenb <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_n[c] <= 1; m_d[c] <= 2; m_k[c] <= 0;
            end
        end else begin
            lk_now  = m_lkp;
            len_new = lk_now ? ((m_len > LC) ? LC + 1 : m_len + 1) : 0;
            run_new = (len_new >= LC + 1);
            act     = m_run && run_new;
            c_v = '0; b_v = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                nn = (m_n[c] > m_d[c]) ? m_d[c] : m_n[c];
                if (act && m_d[c] != 0) begin
                    a = (m_k[c] * nn) % m_d[c];
                    s = a + nn;
                    h = m_d[c] / 2;
                    c_v[c] = (s >= m_d[c]);
`ifdef CEN_GEN_PHASE_EN
                    b_v[c] = c_v[c] ? ((s - m_d[c]) >= h) : ((a < h) && (h <= s));
`endif
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_n[c] <= cfg_num; m_d[c] <= cfg_den; m_k[c] <= 0;
                end else if (act && m_d[c] != 0) begin
                    m_k[c] <= m_k[c] + 1;
                end else begin
                    m_k[c] <= 0;
                end
            end
            m_lkp <= locked; m_len <= len_new; m_run <= run_new;
            e_cen <= c_v; e_cenb <= b_v;
        end
    end

    always @(negedge clk) begin : compare
        if (rst_n) begin
            chk("cen", cen, e_cen);
            chk("cen_b", cen_b, e_cenb);
            chk("rst_out_n", rst_out_n, m_run);
            chk("running", running, m_run);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_run(string nm);
        int n = 0;
        bit early = 0;
        do begin
            @(negedge clk); n++;
            if (!running && cen != 0) early = 1;
        end while (!running && n < 100);
        chk(nm, n, 18);
        chk({nm, "_quiet"}, early, 0);
    endtask

    task automatic chk_pattern(string nm);
        logic [3:0] pc, pb;
        pc = 4'b1010;
`ifdef CEN_GEN_PHASE_EN
        pb = 4'b0101;
`else
        pb = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({nm, "_cen"}, cen[0], pc[i]);
            chk({nm, "_cen_b"}, cen_b[0], pb[i]);
        end
    endtask

    task automatic write(int ch, int nu, int de);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_num = ACC_W'(nu); cfg_den = ACC_W'(de);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic count_pulses(int ch, int cycles, output int pulses, output int bad_gap);
        int last = -1;
        pulses = 0; bad_gap = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cen[ch]) begin
                if (last >= 0 && (i - last < 2 || i - last > 3)) bad_gap++;
                last = i; pulses++;
            end
        end
    endtask

    int n, p, g;

    initial begin
        rst_n = 1'b0; locked = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
        repeat (3) @(negedge clk);
        chk("rst_cen", cen, 0); chk("rst_cen_b", cen_b, 0);
        chk("rst_rst_out_n", rst_out_n, 0); chk("rst_running", running, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        locked = 1'b1;
        wait_run("lock_to_run");
        chk_pattern("half_rate");

        locked = 1'b0; n = 0;
        do begin @(negedge clk); n++; end while (rst_out_n && n < 20);
        chk("lockloss_edges", n, 2);
        chk("lockloss_cen", cen, 0);

        locked = 1'b1;
        repeat (12) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        wait_run("glitch_relock");
        chk_pattern("relock");

        write(1, 3, 8);
        count_pulses(1, 800, p, g);
        chk("pulses_3_8", p, 300);
        chk("gap_3_8", g, 0);

        write(5, 1, 1);
        count_pulses(1, 24, p, g);
        chk("ignored_ch5", p, 9);

        write(0, 1, 0);
        count_pulses(0, 50, p, g);
        chk("den0_quiet", p, 0);

        write(1, 9, 4);
        count_pulses(1, 50, p, g);
        chk("num_gt_den", p, 50);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1; cfg_ch = 3'($urandom_range(0, 7));
                cfg_num = ACC_W'($urandom_range(0, 20)); cfg_den = ACC_W'($urandom_range(0, 20));
            end else begin
                cfg_we = 1'b0;
            end
            if (i > 40 && i < 560 && $urandom_range(0, 149) == 0) locked = 1'b0;
            else if (!locked && $urandom_range(0, 2) == 0) locked = 1'b1;
            @(negedge clk);
        end
        cfg_we = 1'b0; locked = 1'b1;
        repeat (40) @(negedge clk);

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cen", cen, 0); chk("async_rst_cen_b", cen_b, 0);
        chk("async_rst_rst_out_n", rst_out_n, 0); chk("async_rst_running", running, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
